// File: rtl/regread_sequencer.sv
// Read-port-2 sequencer for the decode stage: time-multiplexes one register
// file port to fetch R1 and (optionally) R3, then hands both to execute.
module regread_sequencer #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_three_src,
  input  logic [AW-1:0] in_r1,
  input  logic [AW-1:0] in_r3,
  output logic          port2_sel,
  output logic [AW-1:0] port2_addr,
  input  logic [DW-1:0] port2_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r1_data,
  output logic [DW-1:0] out_r3_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [AW-1:0] r_r1_q;
  logic [AW-1:0] r_r3_q;
  logic          r_three_q;
  logic [DW-1:0] r_r1_data;
  logic [DW-1:0] r_r3_data;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_sel;
  logic [AW-1:0] w_addr;
  logic          w_cap_r1;
  logic          w_cap_r3;

  // Three-source requests read R3 first so R1 is always the final read.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_sel      = 1'b0;
    w_addr     = '0;
    w_cap_r1   = 1'b0;
    w_cap_r3   = 1'b0;
    w_accept   = 1'b0;

    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
      end
      RD_A: begin
        if (r_three_q) begin
          w_sel    = 1'b0;
          w_addr   = r_r3_q;
          w_cap_r3 = 1'b1;
          w_next   = RD_B;
        end else begin
          w_sel    = 1'b1;
          w_addr   = r_r1_q;
          w_cap_r1 = 1'b1;
          w_next   = DONE;
        end
      end
      RD_B: begin
        w_sel    = 1'b1;
        w_addr   = r_r1_q;
        w_cap_r1 = 1'b1;
        w_next   = DONE;
      end
      DONE: begin
        w_in_ready = out_ready;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    if (reset) begin
      w_in_ready = 1'b0;
    end

    // Accept in DONE overlaps the output handshake for back-to-back issue.
    w_accept = in_valid && w_in_ready;
    if (w_accept) begin
      w_next = RD_A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_r1_q    <= '0;
      r_r3_q    <= '0;
      r_three_q <= 1'b0;
      r_r1_data <= '0;
      r_r3_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_r1_q    <= in_r1;
        r_r3_q    <= in_r3;
        r_three_q <= in_three_src;
        r_r3_data <= '0;
      end
      if (w_cap_r1) begin
        r_r1_data <= port2_data;
      end
      if (w_cap_r3) begin
        r_r3_data <= port2_data;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign port2_sel   = w_sel;
  assign port2_addr  = w_addr;
  assign out_valid   = (r_state == DONE);
  assign out_r1_data = r_r1_data;
  assign out_r3_data = r_r3_data;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_regread_sequencer.sv
// Directed bench for regread_sequencer with a behavioural register file on port 2.
module tb_regread_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_three_src;
  logic [AW-1:0] in_r1;
  logic [AW-1:0] in_r3;
  logic          port2_sel;
  logic [AW-1:0] port2_addr;
  logic [DW-1:0] port2_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r1_data;
  logic [DW-1:0] out_r3_data;
  logic          busy;

  logic [DW-1:0] rf [0:31];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          three;
    logic [AW-1:0] r1;
    logic [AW-1:0] r3;
    logic [DW-1:0] e1;
    logic [DW-1:0] e3;
  } req_t;

  regread_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_three_src (in_three_src),
    .in_r1        (in_r1),
    .in_r3        (in_r3),
    .port2_sel    (port2_sel),
    .port2_addr   (port2_addr),
    .port2_data   (port2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_r1_data  (out_r1_data),
    .out_r3_data  (out_r3_data),
    .busy         (busy)
  );

  assign port2_data = rf[port2_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One request issued from IDLE, checked cycle by cycle, then drained.
  task automatic run_req(input req_t r, input string tag);
    @(posedge clk); #1;
    in_valid = 1'b1; in_three_src = r.three; in_r1 = r.r1; in_r3 = r.r3; out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".acc_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_r1 = ~r.r1; in_r3 = ~r.r3;
    @(negedge clk);
    chk({tag, ".a_busy"}, 32'(busy), 32'd1);
    chk({tag, ".a_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".a_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".a_sel"}, 32'(port2_sel), r.three ? 32'd0 : 32'd1);
    chk({tag, ".a_addr"}, 32'(port2_addr), r.three ? 32'(r.r3) : 32'(r.r1));
    if (r.three) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, ".b_sel"}, 32'(port2_sel), 32'd1);
      chk({tag, ".b_addr"}, 32'(port2_addr), 32'(r.r1));
      chk({tag, ".b_out_valid"}, 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".d_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".d_r1"}, 32'(out_r1_data), 32'(r.e1));
    chk({tag, ".d_r3"}, 32'(out_r3_data), 32'(r.e3));
    chk({tag, ".d_addr"}, 32'(port2_addr), 32'd0);
    chk({tag, ".d_sel"}, 32'(port2_sel), 32'd0);
    chk({tag, ".d_in_ready_hold"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk({tag, ".d_in_ready_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  req_t vec [6];
  req_t strm [4];
  int   strm_at [4];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 16'h1000 + 16'(i * 16'h0111);
    rf[0]  = 16'h0001;
    rf[2]  = 16'hAAAA;
    rf[4]  = 16'h0C0C;
    rf[5]  = 16'h5A5A;
    rf[7]  = 16'h1234;
    rf[9]  = 16'h5555;
    rf[31] = 16'hFFFF;

    vec[0] = '{1'b0, 5'd7,  5'd3,  16'h1234, 16'h0000};
    vec[1] = '{1'b1, 5'd2,  5'd9,  16'hAAAA, 16'h5555};
    vec[2] = '{1'b0, 5'd31, 5'd2,  16'hFFFF, 16'h0000};
    vec[3] = '{1'b1, 5'd31, 5'd0,  16'hFFFF, 16'h0001};
    vec[4] = '{1'b1, 5'd7,  5'd7,  16'h1234, 16'h1234};
    vec[5] = '{1'b0, 5'd0,  5'd31, 16'h0001, 16'h0000};

    strm[0] = '{1'b0, 5'd4,  5'd1, 16'h0C0C, 16'h0000};
    strm[1] = '{1'b1, 5'd9,  5'd2, 16'h5555, 16'hAAAA};
    strm[2] = '{1'b0, 5'd31, 5'd5, 16'hFFFF, 16'h0000};
    strm[3] = '{1'b1, 5'd0,  5'd7, 16'h0001, 16'h1234};
    strm_at[0] = 2; strm_at[1] = 5; strm_at[2] = 7; strm_at[3] = 10;

    reset = 1'b1; in_valid = 1'b0; in_three_src = 1'b0;
    in_r1 = '0; in_r3 = '0; out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.r1", 32'(out_r1_data), 32'd0);
    chk("rst.r3", 32'(out_r3_data), 32'd0);
    chk("rst.sel", 32'(port2_sel), 32'd0);
    chk("rst.addr", 32'(port2_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_req(vec[i], $sformatf("vec%0d", i));

    // Back-pressure: DONE held 5 cycles with a pending request.
    @(posedge clk); #1;
    in_valid = 1'b1; in_three_src = 1'b0; in_r1 = 5'd5; in_r3 = 5'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_three_src = 1'b1; in_r1 = 5'd2; in_r3 = 5'd9;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.r1", i), 32'(out_r1_data), 32'h5A5A);
      chk($sformatf("bp%0d.r3", i), 32'(out_r3_data), 32'd0);
      chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.rel_in_ready", 32'(in_ready), 32'd1);
    chk("bp.rel_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("bp.a_out_valid", 32'(out_valid), 32'd0);
    chk("bp.a_sel", 32'(port2_sel), 32'd0);
    chk("bp.a_addr", 32'(port2_addr), 32'd9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.b_addr", 32'(port2_addr), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.d_out_valid", 32'(out_valid), 32'd1);
    chk("bp.d_r1", 32'(out_r1_data), 32'hAAAA);
    chk("bp.d_r3", 32'(out_r3_data), 32'h5555);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp.idle_busy", 32'(busy), 32'd0);

    // Back-to-back stream: results expected at cycles 2, 5, 7, 10.
    for (int c = 0; c < 12; c++) begin
      int k;
      logic exp_v;
      int   exp_k;
      @(posedge clk); #1;
      k = (c < 2) ? 0 : (c < 5) ? 1 : (c < 7) ? 2 : 3;
      out_ready = 1'b1;
      in_valid = (c <= 7);
      in_three_src = strm[k].three; in_r1 = strm[k].r1; in_r3 = strm[k].r3;
      exp_v = 1'b0; exp_k = 0;
      for (int j = 0; j < 4; j++) if (strm_at[j] == c) begin exp_v = 1'b1; exp_k = j; end
      @(negedge clk);
      chk($sformatf("strm.c%0d.out_valid", c), 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("strm.c%0d.r1", c), 32'(out_r1_data), 32'(strm[exp_k].e1));
        chk($sformatf("strm.c%0d.r3", c), 32'(out_r3_data), 32'(strm[exp_k].e3));
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;

    // Reset landing during RD_B.
    @(posedge clk); #1;
    in_valid = 1'b1; in_three_src = 1'b1; in_r1 = 5'd2; in_r3 = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("rstb.rdb_addr", 32'(port2_addr), 32'd2);
    chk("rstb.rdb_busy", 32'(busy), 32'd1);
    chk("rstb.rdb_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstb.busy", 32'(busy), 32'd0);
    chk("rstb.out_valid", 32'(out_valid), 32'd0);
    chk("rstb.r1", 32'(out_r1_data), 32'd0);
    chk("rstb.r3", 32'(out_r3_data), 32'd0);
    chk("rstb.sel", 32'(port2_sel), 32'd0);
    chk("rstb.addr", 32'(port2_addr), 32'd0);
    chk("rstb.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rstb.post_in_ready", 32'(in_ready), 32'd1);
    chk("rstb.post_busy", 32'(busy), 32'd0);
    run_req(vec[1], "rstb.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
